// File: rtl/ps2_key_display_pkg.sv
// Shared constants and types for the PS/2 key display: protocol bytes,
// decoder FSM state encoding and 7-segment patterns.
package ps2_key_display_pkg;

  // Scan-code prefix bytes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  // Active-low 7-segment patterns (gfedcba)
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  // Protocol decoder states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

endpackage : ps2_key_display_pkg

// File: rtl/ps2_key_display_hex_to_seg7.sv
// Purely combinational hex digit to active-low 7-segment glyph (gfedcba).
//   hex_i : 4-bit value
//   seg_o : 7-bit active-low segment pattern
module hex_to_seg7 (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (hex_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule : hex_to_seg7

// File: rtl/ps2_key_display.sv
// PS/2 scan-code decoder and key display. Decodes make/break/E0 sequences
// from the receiver byte stream, tracks the held key and a press count, and
// drives NUM_DIGITS active-low 7-segment digits.
//   clk, clrn   : clock, async active-low reset
//   data_valid  : one-cycle strobe, data holds a new byte
//   data        : received scan-code byte
//   key_held    : a key is currently held
//   key_code    : last accepted make code (E0 stripped)
//   key_ext     : key_code came from an E0 sequence
//   press_count : distinct key presses, wrapping
//   seg         : digit i on seg[7i+6:7i]; digits 0-1 code, 2.. count
module ps2_key_display
  import ps2_key_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter bit          LZ_BLANK   = 1'b1,
  parameter int unsigned CNT_W      = 4 * (NUM_DIGITS - 2)
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic                    data_valid,
  input  logic [7:0]              data,
  output logic                    key_held,
  output logic [7:0]              key_code,
  output logic                    key_ext,
  output logic [CNT_W-1:0]        press_count,
  output logic [7*NUM_DIGITS-1:0] seg
);

  ps2_state_e              state_q, state_d;
  logic                    key_held_q;
  logic [7:0]              key_code_q;
  logic                    key_ext_q;
  logic [CNT_W-1:0]        press_count_q;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d, seg_rst;

  logic do_make, do_brk, ev_ext, same_key;

  // Protocol decode: classify the incoming byte and pick the next state
  always_comb begin
    state_d = state_q;
    do_make = 1'b0;
    do_brk  = 1'b0;
    ev_ext  = 1'b0;
    if (data_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (data == SC_EXT)        state_d = ST_EXT;
          else if (data == SC_BREAK) state_d = ST_BRK;
          else                       do_make = 1'b1;
        end
        ST_EXT: begin
          if (data == SC_BREAK)    state_d = ST_EXT_BRK;
          else if (data == SC_EXT) state_d = ST_EXT;
          else begin
            do_make = 1'b1;
            ev_ext  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          // E0 after F0 is a slip: drop the break, start an extended code
          if (data == SC_BREAK)    state_d = ST_BRK;
          else if (data == SC_EXT) state_d = ST_EXT;
          else begin
            do_brk  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (data != SC_EXT && data != SC_BREAK) begin
            do_brk = 1'b1;
            ev_ext = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign same_key = key_held_q && (data == key_code_q) && (ev_ext == key_ext_q);

  // FSM state and key tracking; a make of the held key is typematic repeat
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q       <= ST_IDLE;
      key_held_q    <= 1'b0;
      key_code_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      press_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (do_make && !same_key) begin
        key_code_q    <= data;
        key_ext_q     <= ev_ext;
        key_held_q    <= 1'b1;
        press_count_q <= press_count_q + CNT_W'(1);
      end else if (do_brk && same_key) begin
        key_held_q <= 1'b0;
      end
    end
  end

  // Per-digit glyph selection and blanking
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic [3:0] nib;
    logic [6:0] glyph;
    logic       blank;

    if (g < 2) begin : g_code
      assign nib   = key_code_q[4*g +: 4];
      assign blank = !key_held_q;
    end else if (g == 2) begin : g_cnt_lsd
      assign nib   = press_count_q[3:0];
      assign blank = 1'b0;
    end else begin : g_cnt
      // Leading zero: this nibble and everything above it is zero
      assign nib   = press_count_q[4*(g-2) +: 4];
      assign blank = LZ_BLANK && (press_count_q[CNT_W-1:4*(g-2)] == '0);
    end

    hex_to_seg7 u_hex (
      .hex_i (nib),
      .seg_o (glyph)
    );

    assign seg_d[7*g +: 7]   = blank ? SEG_BLANK : glyph;
    assign seg_rst[7*g +: 7] = (g == 2 || (g > 2 && !LZ_BLANK)) ? SEG_ZERO : SEG_BLANK;
  end

  // Display register, one cycle behind the key state
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) seg_q <= seg_rst;
    else       seg_q <= seg_d;
  end

  assign key_held    = key_held_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign press_count = press_count_q;
  assign seg         = seg_q;

endmodule : ps2_key_display

// File: tb/tb_ps2_key_display.sv
// Directed bench for ps2_key_display: a 6-digit instance plus two 4-digit
// instances (leading-zero blanking on and off) sharing one byte stream.
module tb_ps2_key_display;

  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] GC = 7'b1000110;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        data_valid = 1'b0;
  logic [7:0]  data = 8'h00;

  logic        held6, ext6;
  logic [7:0]  code6;
  logic [15:0] cnt6;
  logic [41:0] seg6;

  logic        held_a, ext_a, held_b, ext_b;
  logic [7:0]  code_a, code_b, cnt_a, cnt_b;
  logic [27:0] seg_a, seg_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ps2_key_display #(.NUM_DIGITS(6), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .clrn(clrn), .data_valid(data_valid), .data(data),
    .key_held(held6), .key_code(code6), .key_ext(ext6),
    .press_count(cnt6), .seg(seg6)
  );

  ps2_key_display #(.NUM_DIGITS(4), .LZ_BLANK(1'b1)) dut_a (
    .clk(clk), .clrn(clrn), .data_valid(data_valid), .data(data),
    .key_held(held_a), .key_code(code_a), .key_ext(ext_a),
    .press_count(cnt_a), .seg(seg_a)
  );

  ps2_key_display #(.NUM_DIGITS(4), .LZ_BLANK(1'b0)) dut_b (
    .clk(clk), .clrn(clrn), .data_valid(data_valid), .data(data),
    .key_held(held_b), .key_code(code_b), .key_ext(ext_b),
    .press_count(cnt_b), .seg(seg_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One byte strobe; returns at the negedge after seg has caught up
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    data       = b;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] c;

    // 1: reset and idle
    do_reset();
    repeat (5) @(negedge clk);
    check("rst_seg6", 64'(seg6), 64'({BL, BL, BL, G0, BL, BL}));
    check("rst_cnt6", 64'(cnt6), 64'd0);
    check("rst_held", 64'(held6), 64'd0);
    check("rst_code", 64'(code6), 64'h00);
    check("rst_seg_a", 64'(seg_a), 64'({BL, G0, BL, BL}));
    check("rst_seg_b", 64'(seg_b), 64'({G0, G0, BL, BL}));

    // 2: make, typematic repeats, break
    send(8'h1C);
    check("mk_held", 64'(held6), 64'd1);
    check("mk_code", 64'(code6), 64'h1C);
    check("mk_cnt", 64'(cnt6), 64'd1);
    check("mk_seg", 64'(seg6), 64'({BL, BL, BL, G1, G1, GC}));
    send(8'h1C);
    send(8'h1C);
    check("rep_cnt", 64'(cnt6), 64'd1);
    send(8'hF0);
    send(8'h1C);
    check("brk_held", 64'(held6), 64'd0);
    check("brk_code", 64'(code6), 64'h1C);
    check("brk_seg", 64'(seg6), 64'({BL, BL, BL, G1, BL, BL}));

    // 3: extended make, plain break ignored, extended break
    send(8'hE0);
    send(8'h75);
    check("ext_flag", 64'(ext6), 64'd1);
    check("ext_code", 64'(code6), 64'h75);
    check("ext_cnt", 64'(cnt6), 64'd2);
    check("ext_seg", 64'(seg6), 64'({BL, BL, BL, G2, G7, G5}));
    send(8'hF0);
    send(8'h75);
    check("plain_brk_ign", 64'(held6), 64'd1);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check("ext_brk_held", 64'(held6), 64'd0);
    check("ext_brk_seg", 64'(seg6), 64'({BL, BL, BL, G2, BL, BL}));

    // 4: rollover to a second key
    send(8'h1C);
    check("k1_ext", 64'(ext6), 64'd0);
    send(8'h32);
    check("k2_cnt", 64'(cnt6), 64'd4);
    check("k2_code", 64'(code6), 64'h32);
    check("k2_seg", 64'(seg6), 64'({BL, BL, BL, G4, G3, G2}));
    send(8'hF0);
    send(8'h1C);
    check("old_brk_ign", 64'(held6), 64'd1);
    send(8'hF0);
    send(8'h32);
    check("new_brk", 64'(held6), 64'd0);

    // 5: reset after F0 discards the pending break
    send(8'hF0);
    do_reset();
    check("mid_rst_cnt", 64'(cnt6), 64'd0);
    send(8'h1C);
    check("post_rst_held", 64'(held6), 64'd1);
    check("post_rst_cnt", 64'(cnt6), 64'd1);
    check("post_rst_seg", 64'(seg6), 64'({BL, BL, BL, G1, G1, GC}));
    // F0 E0 slip: break dropped, following byte is an extended make
    send(8'hF0);
    send(8'hE0);
    send(8'h75);
    check("slip_cnt", 64'(cnt6), 64'd2);
    check("slip_ext", 64'(ext6), 64'd1);
    check("slip_held", 64'(held6), 64'd1);
    // EXT_BRK drops a stray E0 and returns to IDLE
    send(8'hE0);
    send(8'hF0);
    send(8'hE0);
    send(8'h75);
    check("xb_drop_make", 64'(cnt6), 64'd3);
    check("xb_drop_ext", 64'(ext6), 64'd0);

    // 6: 257 presses, 8-bit counter wraps on the 4-digit instances
    do_reset();
    for (int i = 0; i < 257; i++) begin
      c = (i % 2 == 1) ? 8'h32 : 8'h1C;
      send(c);
      send(8'hF0);
      send(c);
      if (i == 15) begin
        check("c16_cnt_a", 64'(cnt_a), 64'h10);
        check("c16_seg_a", 64'(seg_a), 64'({G1, G0, BL, BL}));
        check("c16_seg_b", 64'(seg_b), 64'({G1, G0, BL, BL}));
      end
    end
    check("wrap_cnt_a", 64'(cnt_a), 64'h01);
    check("wrap_cnt_b", 64'(cnt_b), 64'h01);
    check("wrap_seg_a", 64'(seg_a), 64'({BL, G1, BL, BL}));
    check("wrap_seg_b", 64'(seg_b), 64'({G0, G1, BL, BL}));
    check("wrap_cnt6", 64'(cnt6), 64'h0101);
    check("wrap_seg6", 64'(seg6), 64'({BL, G1, G0, G1, BL, BL}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ps2_key_display

// File: doc/ps2_key_display.md
Name: ps2_key_display

Overview:
- Successor to the two-digit scan-code display.
- Consumes the byte stream from the PS/2 receiver and decodes the make/break/extended (E0) protocol itself, replacing the external pre flag and F0 compare.
- Tracks the currently held key and a running key-press count, and drives NUM_DIGITS active-low 7-segment digits.
- Sits between the PS/2 receiver and the board HEX pins.

Parameters:
- NUM_DIGITS, 6, total 7-seg digits driven; minimum 3. Digits 0-1 show the key code; digits 2..NUM_DIGITS-1 show the press count.
- LZ_BLANK, 1, 1 = blank leading-zero count digits; digit 2 is always lit.
- CNT_W, 4*(NUM_DIGITS-2), derived press-counter width; not overridden.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- clrn, input, 1, asynchronous active-low reset.
- data_valid, input, 1, one-cycle strobe: data holds a new received byte.
- data, input, 8, received scan-code byte.
- key_held, output, 1, a key is currently held.
- key_code, output, 8, last make code accepted, E0 prefix stripped.
- key_ext, output, 1, key_code came from an E0-prefixed sequence.
- press_count, output, CNT_W, number of distinct key presses, wrapping.
- seg, output, 7*NUM_DIGITS, digit i on seg[7i+6:7i], bit order gfedcba, active low.

Behaviour:
Clock and reset:
- Single clock domain.
- clrn low asynchronously forces: state IDLE, key_held 0, key_code 8'h00, key_ext 0, press_count 0.
- seg resets to the idle pattern:
  - digits 0-1 = 7'b1111111.
  - digit 2 = 7'b1000000.
  - digits 3 and up = 7'b1111111 if LZ_BLANK, else 7'b1000000.
- Reset mid-sequence (for example after E0 or F0) discards the partial sequence.

Protocol FSM, advanced only when data_valid = 1; otherwise all state holds:
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - other -> make(data, 0), stay IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> EXT.
  - other -> make(data, 1) -> IDLE.
- BRK:
  - F0 -> BRK.
  - E0 -> EXT; this is a protocol slip and the break is discarded.
  - other -> break(data, 0) -> IDLE.
- EXT_BRK:
  - E0 or F0 -> IDLE; the byte is dropped.
  - other -> break(data, 1) -> IDLE.

make(c, e):
- If key_held and c == key_code and e == key_ext, it is a typematic repeat: no change.
- Otherwise: key_code <= c, key_ext <= e, key_held <= 1, press_count <= press_count + 1, modulo 2^CNT_W.
- A different key while one is held counts as a new press and replaces the held key.

break(c, e):
- If key_held and c == key_code and e == key_ext: key_held <= 0.
- Otherwise ignored. key_code and key_ext are retained after release.

Display:
- seg is registered and computed from the registered state.
- Latency: data_valid sampled at edge N updates the state at N; seg reflects it at edge N+1.
- Digit 1 = key_code[7:4], digit 0 = key_code[3:0], hex glyphs as in the existing decoder (0 = 1000000 ... F = 0001110).
- Both code digits are 1111111 whenever key_held = 0.
- Count digit k (k >= 2) = press_count[4(k-2)+3 : 4(k-2)].
- With LZ_BLANK, a count digit above digit 2 is blanked when it and all higher count nibbles are zero.

Decomposition:
- Include file ps2_defs.vh holds:
  - SC_EXT = 8'hE0 and SC_BREAK = 8'hF0.
  - FSM state encodings (IDLE, EXT, BRK, EXT_BRK; 2 bits).
  - SEG_BLANK = 7'h7F.
- Sub-module hex_to_seg7: 4-bit in, 7-bit active-low out, purely combinational.
  - Instantiated NUM_DIGITS times via generate.
  - Blanking and the seg register stay in ps2_key_display.

Test Plan:
1. Reset, release, idle 5 cycles -> seg = {6{...}} with HEX0/HEX1 = 1111111, HEX2 = 1000000, HEX3-5 = 1111111; press_count = 0.
2. Bytes 1C, 1C, 1C (typematic), then F0, 1C:
   - After the first byte: key_held = 1, key_code = 1C, press_count = 1, HEX0 = 1000110, HEX1 = 1111001, HEX2 = 1111001.
   - Repeats leave the count at 1.
   - After F0 1C: key_held = 0 and HEX0/HEX1 blank.
3. E0 75 then E0 F0 75:
   - key_ext = 1, key_code = 75, count +1.
   - Break clears key_held.
   - A plain F0 75 instead leaves key_held = 1.
4. Press 1C, then 32 without releasing:
   - press_count = 2, key_code = 32.
   - F0 1C ignored (key_held stays 1); F0 32 clears it.
5. Assert clrn low one cycle after an F0 byte, release, send 1C -> treated as make: key_held = 1, count = 1.
6. NUM_DIGITS = 4, 257 distinct presses (alternating 1C/32 with breaks) -> press_count wraps to 8'h01, HEX3 blank with LZ_BLANK = 1, 1000000 with LZ_BLANK = 0.
